accu_tx10: RTL and testbench

Transmit-side counterpart of the 10-bit accumulator receiver in the VLC datapath. Accepts 10-bit intensity samples over a valid/ready handshake and serialises each one into a fixed-length frame of single-bit LED drive values. Each frame holds exactly as many ones as the sample value, so the receiver's integrator recovers the sample. Sits between the sample source and the LED driver.

---
 rtl/accu_pkg.sv | 15 +
 rtl/accu_tx_step.sv | 32 +++
 rtl/accu_tx10.sv | 159 +++++++++++++++
 tb/tb_accu_tx10.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/accu_pkg.sv
// accu_pkg: shared definitions for the VLC accumulator transmit/receive blocks.
//   ACCU_W             default sample width
//   ACCU_FRAME_LEN_DEF default frame length (bits per frame)
//   accu_tx_state_t    transmitter state encoding
package accu_pkg;

   localparam int ACCU_W             = 10;
   localparam int ACCU_FRAME_LEN_DEF = 1023;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } accu_tx_state_t;

endpackage

// File: rtl/accu_tx_step.sv
// accu_tx_step: one sigma-delta spreading step for accu_tx10.
//   acc      in   error accumulator, kept in [0, FRAME_LEN)
//   level    in   ones to place in the frame, 0..FRAME_LEN
//   bit_out  out  drive bit for this step
//   acc_next out  accumulator after this step
// Purely combinational; the caller registers bit_out and acc_next.
module accu_tx_step
   import accu_pkg::*;
#(
   parameter int WIDTH     = ACCU_W,
   parameter int FRAME_LEN = ACCU_FRAME_LEN_DEF
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] level,
   output logic             bit_out,
   output logic [WIDTH-1:0] acc_next
);

   localparam logic [WIDTH:0] FLX = (WIDTH+1)'(FRAME_LEN);

   // acc + level can reach 2*FRAME_LEN-1, so one extra bit is needed
   logic [WIDTH:0] nxt;
   logic [WIDTH:0] wrapped;

   always_comb begin
      nxt      = {1'b0, acc} + {1'b0, level};
      wrapped  = nxt - FLX;
      bit_out  = (nxt >= FLX);
      acc_next = bit_out ? wrapped[WIDTH-1:0] : nxt[WIDTH-1:0];
   end

endmodule

// File: rtl/accu_tx10.sv
// accu_tx10: serialises WIDTH-bit intensity samples into FRAME_LEN-bit
// frames of LED drive bits containing exactly `sample` ones.
//   clk, rst     clock, synchronous active-high reset
//   in_data      sample (number of ones); values above FRAME_LEN are clamped
//   in_valid     sample present
//   in_ready     one-entry buffer empty and not in reset
//   out          serial drive bit
//   out_valid    out belongs to an active frame
//   frame_start  first bit of each frame
//   underrun     frame ended with no sample buffered (one-cycle pulse)
//   sat          last accepted sample was clamped (one-cycle pulse)
// Build option: ACCU_TX_SPREAD_EN defined selects sigma-delta spreading of
// the ones across the frame; undefined selects PWM ordering (ones first).
module accu_tx10
   import accu_pkg::*;
#(
   parameter int WIDTH     = ACCU_W,
   parameter int FRAME_LEN = ACCU_FRAME_LEN_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out,
   output logic             out_valid,
   output logic             frame_start,
   output logic             underrun,
   output logic             sat
);

   localparam logic [WIDTH-1:0] FL   = WIDTH'(FRAME_LEN);
   localparam logic [WIDTH-1:0] LAST = WIDTH'(FRAME_LEN - 1);

   function automatic logic [WIDTH-1:0] clamp_level(input logic [WIDTH-1:0] v);
      return (v > FL) ? FL : v;
   endfunction

   accu_tx_state_t   state;
   logic [WIDTH-1:0] cnt;        // index of the bit currently on out
   logic [WIDTH-1:0] cnt_inc;
   logic [WIDTH-1:0] level;
   logic [WIDTH-1:0] hold_data;
   logic             hold_full;
   logic             accept;
   logic             last;
   logic             load;
   logic             bit_next;

   assign in_ready = !hold_full && !rst;
   assign accept   = in_valid && in_ready;
   assign last     = (state == SEND) && (cnt == LAST);
   // A frame is loaded from IDLE or directly after the last bit (no gap)
   assign load     = hold_full && ((state == IDLE) || last);
   assign cnt_inc  = cnt + WIDTH'(1);

`ifdef ACCU_TX_SPREAD_EN
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] step_acc;
   logic [WIDTH-1:0] step_lvl;
   logic [WIDTH-1:0] step_acc_next;
   logic             step_bit;

   // On a load the first bit is computed from a cleared accumulator and
   // the buffered level, so the frame starts with no stale error.
   always_comb begin
      step_acc = acc;
      step_lvl = level;
      if (load) begin
         step_acc = '0;
         step_lvl = hold_data;
      end
   end

   accu_tx_step #(
      .WIDTH     (WIDTH),
      .FRAME_LEN (FRAME_LEN)
   ) u_step (
      .acc      (step_acc),
      .level    (step_lvl),
      .bit_out  (step_bit),
      .acc_next (step_acc_next)
   );

   assign bit_next = step_bit;

   // The last bit of a frame always wraps acc back to 0
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (load || ((state == SEND) && !last)) begin
         acc <= step_acc_next;
      end
   end
`else
   // PWM: bit index < level, with index 0 on a load
   assign bit_next = load ? (hold_data != '0) : (cnt_inc < level);
`endif

   // Data registers: not reset, only qualified by accept / load
   always_ff @(posedge clk) begin
      if (accept) begin
         hold_data <= clamp_level(in_data);
      end
      if (load) begin
         level <= hold_data;
      end
   end

   // Control: buffer flag, frame FSM and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         hold_full   <= 1'b0;
         cnt         <= '0;
         out         <= 1'b0;
         out_valid   <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         sat         <= 1'b0;
      end else begin
         frame_start <= load;
         underrun    <= 1'b0;
         sat         <= accept && (in_data > FL);

         if (accept) begin
            hold_full <= 1'b1;
         end else if (load) begin
            hold_full <= 1'b0;
         end

         if (load) begin
            state     <= SEND;
            cnt       <= '0;
            out       <= bit_next;
            out_valid <= 1'b1;
         end else begin
            case (state)
               SEND: begin
                  if (last) begin
                     state     <= IDLE;
                     cnt       <= '0;
                     out       <= 1'b0;
                     out_valid <= 1'b0;
                     underrun  <= 1'b1;
                  end else begin
                     cnt <= cnt_inc;
                     out <= bit_next;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_accu_tx10.sv
module tb_accu_tx10;

   localparam int W    = 10;
   localparam int FLS  = 10;
   localparam int FLB  = 1023;
   localparam int NRND = 40;

   logic clk;
   logic rst;

   // small-frame instance
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic         out;
   logic         out_valid;
   logic         frame_start;
   logic         underrun;
   logic         sat;

   // default-frame instance
   logic [W-1:0] f_in_data;
   logic         f_in_valid;
   logic         f_in_ready;
   logic         f_out;
   logic         f_out_valid;
   logic         f_frame_start;
   logic         f_underrun;
   logic         f_sat;

   accu_tx10 #(.WIDTH(W), .FRAME_LEN(FLS)) u_small (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out(out), .out_valid(out_valid),
      .frame_start(frame_start), .underrun(underrun), .sat(sat)
   );

   accu_tx10 u_full (
      .clk(clk), .rst(rst), .in_data(f_in_data), .in_valid(f_in_valid),
      .in_ready(f_in_ready), .out(f_out), .out_valid(f_out_valid),
      .frame_start(f_frame_start), .underrun(f_underrun), .sat(f_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [W-1:0] data;
      logic [9:0]   bits;   // bit 9 is the first frame bit
      logic         sat;
   } vec_t;

   vec_t vecs[7];

   logic [9:0] bits;
   int         vld_ok, fs_ok, cnt_bad;
   logic       b2b_out[20];
   logic       b2b_vld[20];
   logic       b2b_fs[20];
   logic       b2b_rdy[20];

   int smp[NRND];
   int exp_q[$];
   int frames, len, ones, cyc;
   logic just_ended;
   logic rdy;

   initial begin
`ifdef ACCU_TX_SPREAD_EN
      vecs[0] = '{data: 10'd3,    bits: 10'b0001001001, sat: 1'b0};
      vecs[1] = '{data: 10'd7,    bits: 10'b0110110111, sat: 1'b0};
      vecs[2] = '{data: 10'd1,    bits: 10'b0000000001, sat: 1'b0};
`else
      vecs[0] = '{data: 10'd3,    bits: 10'b1110000000, sat: 1'b0};
      vecs[1] = '{data: 10'd7,    bits: 10'b1111111000, sat: 1'b0};
      vecs[2] = '{data: 10'd1,    bits: 10'b1000000000, sat: 1'b0};
`endif
      vecs[3] = '{data: 10'd0,    bits: 10'b0000000000, sat: 1'b0};
      vecs[4] = '{data: 10'd10,   bits: 10'b1111111111, sat: 1'b0};
      vecs[5] = '{data: 10'd15,   bits: 10'b1111111111, sat: 1'b1};
      vecs[6] = '{data: 10'd1023, bits: 10'b1111111111, sat: 1'b1};

      rst = 1'b1; in_valid = 1'b0; in_data = '0;
      f_in_valid = 1'b0; f_in_data = '0;

      // reset state
      tick(); tick();
      chk("rst_out", out, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_sat", sat, 0);
      chk("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      tick();

      // single frames from idle
      for (int v = 0; v < 7; v++) begin
         bits = '0; vld_ok = 1; fs_ok = 1;
         in_data = vecs[v].data; in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         chk("sat_pulse", sat, vecs[v].sat);
         chk("gap_before_frame", out_valid, 0);
         for (int b = 0; b < FLS; b++) begin
            tick();
            bits = {bits[8:0], out};
            if (!out_valid) vld_ok = 0;
            if (frame_start != (b == 0)) fs_ok = 0;
         end
         chk("frame_bits", bits, vecs[v].bits);
         chk("frame_valid", vld_ok, 1);
         chk("frame_start_pos", fs_ok, 1);
         tick();
         chk("underrun_pulse", underrun, 1);
         chk("idle_after_frame", out_valid, 0);
         tick();
         chk("underrun_single", underrun, 0);
      end

      // back-to-back 0 then 10 with in_valid held
      in_data = 10'd0; in_valid = 1'b1;
      tick();
      chk("b2b_ready_full", in_ready, 0);
      in_data = 10'd10;
      for (int i = 0; i < 20; i++) begin
         tick();
         b2b_out[i] = out; b2b_vld[i] = out_valid;
         b2b_fs[i] = frame_start; b2b_rdy[i] = in_ready;
         if (i == 1) in_valid = 1'b0;
      end
      bits = '0; vld_ok = 1; fs_ok = 1;
      for (int i = 0; i < 10; i++) bits = {bits[8:0], b2b_out[i]};
      chk("b2b_frame0", bits, 10'b0000000000);
      bits = '0;
      for (int i = 10; i < 20; i++) bits = {bits[8:0], b2b_out[i]};
      chk("b2b_frame1", bits, 10'b1111111111);
      for (int i = 0; i < 20; i++) begin
         if (!b2b_vld[i]) vld_ok = 0;
         if (b2b_fs[i] != (i == 0 || i == 10)) fs_ok = 0;
      end
      chk("b2b_no_gap", vld_ok, 1);
      chk("b2b_frame_start", fs_ok, 1);
      chk("b2b_ready_empty", b2b_rdy[0], 1);
      chk("b2b_ready_held", b2b_rdy[5], 0);
      chk("b2b_ready_reload", b2b_rdy[10], 1);
      tick();
      chk("b2b_underrun", underrun, 1);

      // reset on bit 5 with a sample buffered
      tick();
      in_data = 10'd7; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int b = 0; b <= 5; b++) begin
         tick();
         if (b == 0) begin in_data = 10'd4; in_valid = 1'b1; end
         if (b == 1) in_valid = 1'b0;
      end
      chk("mid_buffered", in_ready, 0);
      chk("mid_sending", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", in_ready, 0);
      tick();
      chk("mid_rst_out", out, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_frame_start", frame_start, 0);
      chk("mid_rst_underrun", underrun, 0);
      chk("mid_rst_sat", sat, 0);
      rst = 1'b0;
      tick();
      chk("mid_rel_ready", in_ready, 1);
      cnt_bad = 0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid || underrun || frame_start) cnt_bad++;
         tick();
      end
      chk("mid_no_pending", cnt_bad, 0);

      // default frame length, random samples with random gaps
      smp[0] = 0; smp[1] = 1023; smp[2] = 1;
      for (int i = 3; i < NRND; i++) smp[i] = int'($urandom_range(0, 1023));
      frames = 0; len = 0; ones = 0; just_ended = 1'b0;
      fork
         begin
            for (int i = 0; i < NRND; i++) begin
               for (int g = int'($urandom_range(0, 3)); g > 0; g--) tick();
               f_in_data = W'(smp[i]); f_in_valid = 1'b1;
               cyc = 0;
               do begin
                  rdy = f_in_ready;
                  tick();
                  cyc++;
               end while (!rdy && cyc < 3000);
               if (!rdy) chk("rnd_accept_timeout", 0, 1);
               else exp_q.push_back(smp[i]);
               f_in_valid = 1'b0;
            end
         end
         begin
            for (int c = 0; c < 50000 && frames < NRND; c++) begin
               tick();
               if (just_ended) begin
                  chk("rnd_frame_len", int'(!f_out_valid || f_frame_start), 1);
                  just_ended = 1'b0;
               end
               if (f_out_valid) begin
                  if (f_frame_start) begin len = 0; ones = 0; end
                  len++;
                  ones += int'(f_out);
                  if (len == FLB) begin
                     if (exp_q.size() == 0) chk("rnd_unexpected_frame", 1, 0);
                     else chk("rnd_ones", ones, exp_q.pop_front());
`ifdef ACCU_TX_SPREAD_EN
                     chk("rnd_acc_zero", int'(u_full.acc), 0);
`endif
                     frames++;
                     just_ended = 1'b1;
                  end
               end
            end
         end
      join
      chk("rnd_frames", frames, NRND);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
